// File: rtl/ixc_drive_lt.sv
// ixc_drive_lt: buffered value driver.
// Incoming sample words are queued in a DEPTH-entry FIFO. Each step strobe pops
// the head word onto the registered output ov. A step that finds the buffer
// empty leaves ov unchanged and raises a one-cycle underrun pulse.
// Optional feature: define IXC_DRIVE_LT_UNDERRUN_CNT_EN to add a 16-bit
// saturating underrun event counter (underrun_cnt).

module ixc_drive_lt #(
    parameter int unsigned       WIDTH     = 1,
    parameter int unsigned       DEPTH     = 4,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic                       fclk,
    input  logic                       frst_n,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    input  logic                       step,
    output logic [WIDTH-1:0]           ov,
    output logic                       underrun,
`ifdef IXC_DRIVE_LT_UNDERRUN_CNT_EN
    output logic [15:0]                underrun_cnt,
`endif
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] ov_q, ov_d;
    logic             underrun_q, underrun_d;

    logic             empty;
    logic             push;
    logic             pop;

    assign empty    = (level_q == '0);
    // Ready is a function of fill level and reset only, never of step.
    assign in_ready = (level_q != FULL_LEVEL) && frst_n;
    assign push     = in_valid && in_ready;
    // A step against an empty buffer never bypasses a same-cycle push.
    assign pop      = step && !empty;

    // Next-state computation for pointers, level, output value and underrun flag.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        level_d    = level_q;
        ov_d       = ov_q;
        underrun_d = 1'b0;

        if (push) begin
            wptr_d = wptr_q + AW'(1);
        end

        if (pop) begin
            rptr_d = rptr_q + AW'(1);
            ov_d   = mem[rptr_q];
        end else if (step) begin
            underrun_d = 1'b1;
        end

        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Control state; synchronous active-low reset discards all buffered words.
    always_ff @(posedge fclk) begin
        if (!frst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            ov_q       <= RESET_VAL;
            underrun_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            ov_q       <= ov_d;
            underrun_q <= underrun_d;
        end
    end

    // Buffer storage write; contents are left unreset since level gates reads.
    always_ff @(posedge fclk) begin
        if (push) begin
            mem[wptr_q] <= in_data;
        end
    end

`ifdef IXC_DRIVE_LT_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt_q;

    // Saturating count of underrun events.
    always_ff @(posedge fclk) begin
        if (!frst_n) begin
            underrun_cnt_q <= '0;
        end else if (underrun_d && (underrun_cnt_q != 16'hFFFF)) begin
            underrun_cnt_q <= underrun_cnt_q + 16'd1;
        end
    end

    assign underrun_cnt = underrun_cnt_q;
`endif

    assign ov       = ov_q;
    assign underrun = underrun_q;
    assign level    = level_q;

endmodule

// File: tb/tb_ixc_drive_lt.sv
// Directed bench for ixc_drive_lt with WIDTH=8, DEPTH=4, RESET_VAL=0xA5.
// Inputs change 1 time unit after a rising edge; outputs are checked at the same
// point after the following edge.

module tb_ixc_drive_lt;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam logic [7:0]  RV    = 8'hA5;

    logic       fclk;
    logic       frst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       step;
    logic [7:0] ov;
    logic       underrun;
    logic [2:0] level;
`ifdef IXC_DRIVE_LT_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    ixc_drive_lt #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VAL (RV)
    ) dut (
        .fclk         (fclk),
        .frst_n       (frst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .step         (step),
        .ov           (ov),
        .underrun     (underrun),
`ifdef IXC_DRIVE_LT_UNDERRUN_CNT_EN
        .underrun_cnt (underrun_cnt),
`endif
        .level        (level)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    task automatic tick();
        @(posedge fclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        frst_n   = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        step     = 1'b0;
        tick();
        tick();
        check("rst_in_ready_low", 32'(in_ready), 32'd0);

        // Reset release
        frst_n = 1'b1;
        tick();
        check("rst_ov", 32'(ov), 32'hA5);
        check("rst_level", 32'(level), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_underrun", 32'(underrun), 32'd0);

        // Push three then drain with back-to-back steps
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        check("fill3_level", 32'(level), 32'd3);
        step = 1'b1;
        tick();
        check("drain_ov0", 32'(ov), 32'h11);
        check("drain_lvl0", 32'(level), 32'd2);
        check("drain_ur0", 32'(underrun), 32'd0);
        tick();
        check("drain_ov1", 32'(ov), 32'h22);
        check("drain_lvl1", 32'(level), 32'd1);
        tick();
        check("drain_ov2", 32'(ov), 32'h33);
        check("drain_lvl2", 32'(level), 32'd0);
        check("drain_ur2", 32'(underrun), 32'd0);
        step = 1'b0;
        tick();
        check("idle_ov_hold", 32'(ov), 32'h33);

        // Fill to DEPTH, overflow attempt rejected
        for (int i = 1; i <= 4; i++) push_word(8'(i));
        check("full_level", 32'(level), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        push_word(8'h55);
        check("full_no_push", 32'(level), 32'd4);
        check("full_ov_hold", 32'(ov), 32'h33);
        step = 1'b1;
        tick();
        step = 1'b0;
        check("full_pop_ov", 32'(ov), 32'h01);
        check("full_pop_level", 32'(level), 32'd3);
        check("full_pop_ready", 32'(in_ready), 32'd1);
        step = 1'b1;
        tick();
        check("rest_ov2", 32'(ov), 32'h02);
        tick();
        check("rest_ov3", 32'(ov), 32'h03);
        tick();
        check("rest_ov4", 32'(ov), 32'h04);
        check("rest_level", 32'(level), 32'd0);

        // Step on empty: hold and underrun pulse
        tick();
        step = 1'b0;
        check("ur_ov_hold", 32'(ov), 32'h04);
        check("ur_pulse", 32'(underrun), 32'd1);
`ifdef IXC_DRIVE_LT_UNDERRUN_CNT_EN
        check("ur_cnt1", 32'(underrun_cnt), 32'd1);
`endif
        tick();
        check("ur_pulse_end", 32'(underrun), 32'd0);

        // Push and step together from empty: no bypass
        in_valid = 1'b1;
        in_data  = 8'h44;
        step     = 1'b1;
        tick();
        in_valid = 1'b0;
        check("ps_empty_ur", 32'(underrun), 32'd1);
        check("ps_empty_level", 32'(level), 32'd1);
        check("ps_empty_ov", 32'(ov), 32'h04);
        tick();
        step = 1'b0;
        check("ps_next_ov", 32'(ov), 32'h44);
        check("ps_next_ur", 32'(underrun), 32'd0);
        check("ps_next_level", 32'(level), 32'd0);

        // Push and step together mid-level
        push_word(8'h61);
        push_word(8'h62);
        in_valid = 1'b1;
        in_data  = 8'h63;
        step     = 1'b1;
        tick();
        in_valid = 1'b0;
        check("ps_mid_ov", 32'(ov), 32'h61);
        check("ps_mid_level", 32'(level), 32'd2);
        tick();
        check("ps_mid_ov2", 32'(ov), 32'h62);
        tick();
        step = 1'b0;
        check("ps_mid_ov3", 32'(ov), 32'h63);
        check("ps_mid_lvl3", 32'(level), 32'd0);

        // Reset mid-operation discards buffered words
        push_word(8'h71);
        push_word(8'h72);
        push_word(8'h73);
        frst_n = 1'b0;
        tick();
        check("mid_rst_ov", 32'(ov), 32'hA5);
        check("mid_rst_level", 32'(level), 32'd0);
        frst_n = 1'b1;
        step   = 1'b1;
        tick();
        step = 1'b0;
        check("post_rst_ov", 32'(ov), 32'hA5);
        check("post_rst_ur", 32'(underrun), 32'd1);
        check("post_rst_level", 32'(level), 32'd0);

`ifdef IXC_DRIVE_LT_UNDERRUN_CNT_EN
        check("post_rst_cnt", 32'(underrun_cnt), 32'd1);
        step = 1'b1;
        for (int i = 0; i < 65540; i++) tick();
        step = 1'b0;
        check("cnt_saturate", 32'(underrun_cnt), 32'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
